// File: rtl/k_fetch_if.sv
// Fetch unit bus: instruction-memory port, instruction stream to the
// decoder, and the redirect request from the back end.
interface k_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/k_fetch_unit.sv
// Sequential instruction fetcher feeding a small FIFO with redirect/flush.
// Optional K_FETCH_STALL_CNT_EN adds a saturating full-stall counter output.
module k_fetch_unit #(
    parameter int IMEM_WORDS = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic        clk,
    input  logic        reset,
    k_fetch_if.master   bus
`ifdef K_FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int PW = $clog2(IMEM_WORDS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PC_RST = PW'(RESET_PC);

    logic [PW-1:0] r_pc;
    logic [PW-1:0] w_pc_nxt;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] w_rd_nxt;
    logic [AW-1:0] w_wr_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_pop;

    logic [31:0]   r_data [FIFO_DEPTH];
    logic [PW-1:0] r_epc  [FIFO_DEPTH];

    logic [31:0]   r_head_data;
    logic [31:0]   w_head_data_nxt;
    logic [PW-1:0] r_head_pc;
    logic [PW-1:0] w_head_pc_nxt;

    logic w_xfer;
    logic w_push;
    logic w_unused;

    assign w_unused = ^bus.redirect_pc[31:PW];

    assign w_xfer = (r_cnt != '0) && bus.inst_ready;
    assign w_push = !bus.redirect && ((r_cnt != FULL) || w_xfer);

    always_comb begin
        w_rd_nxt        = r_rd + AW'(w_xfer);
        w_wr_nxt        = r_wr;
        w_pc_nxt        = r_pc;
        w_cnt_pop       = r_cnt - CW'(w_xfer);
        w_cnt_nxt       = w_cnt_pop;
        w_head_data_nxt = r_head_data;
        w_head_pc_nxt   = r_head_pc;

        if (bus.redirect) begin
            w_rd_nxt  = '0;
            w_wr_nxt  = '0;
            w_cnt_nxt = '0;
            w_pc_nxt  = bus.redirect_pc[PW-1:0];
        end else if (w_push) begin
            w_wr_nxt  = r_wr + AW'(1);
            w_cnt_nxt = w_cnt_pop + CW'(1);
            w_pc_nxt  = r_pc + PW'(1);
        end

        // Head register tracks the entry that will be at rd_ptr next cycle;
        // when the buffer drains it keeps the last value.
        if (!bus.redirect && (w_cnt_nxt != '0)) begin
            if (w_cnt_pop == '0) begin
                w_head_data_nxt = bus.imem_instr;
                w_head_pc_nxt   = r_pc;
            end else begin
                w_head_data_nxt = r_data[w_rd_nxt];
                w_head_pc_nxt   = r_epc[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= PC_RST;
            r_rd        <= '0;
            r_wr        <= '0;
            r_cnt       <= '0;
            r_head_data <= '0;
            r_head_pc   <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_rd        <= w_rd_nxt;
            r_wr        <= w_wr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_head_data <= w_head_data_nxt;
            r_head_pc   <= w_head_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_data[r_wr] <= bus.imem_instr;
            r_epc[r_wr]  <= r_pc;
        end
    end

    assign bus.imem_addr  = {{(32-PW){1'b0}}, r_pc};
    assign bus.inst_valid = (r_cnt != '0);
    assign bus.inst_data  = r_head_data;
    assign bus.inst_pc    = {{(32-PW){1'b0}}, r_head_pc};

`ifdef K_FETCH_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if ((r_cnt == FULL) && !w_xfer && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif
endmodule

// File: doc/k_fetch_unit.md
K_FETCH_UNIT -- requirements
Module: k_fetch_unit

Interface
REQ-001 Parameter IMEM_WORDS, default 1024: instruction memory depth in words; power of two, 2..65536.
REQ-002 Parameter FIFO_DEPTH, default 4: fetch buffer entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0: word index fetched first after reset; less than IMEM_WORDS.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 imem_addr  output  32  word index driven to the instruction memory, zero-extended from the PC.
REQ-008 imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-009 inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 inst_ready  input  1  consumer accepts the head; a transfer occurs on a cycle when inst_valid and inst_ready are both 1.
REQ-011 inst_data  output  32  instruction at the buffer head.
REQ-012 inst_pc  output  32  word index of inst_data, zero-extended.
REQ-013 redirect  input  1  flush the buffer and restart fetch at redirect_pc.
REQ-014 redirect_pc  input  32  new fetch word index; only the low log2(IMEM_WORDS) bits are used.

Function
REQ-015 imem_addr SHALL equal the registered PC every cycle, with no combinational path from any input.
REQ-016 Push: on a cycle with no redirect, {imem_instr, PC} SHALL be written to the tail when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a transfer occurs in the same cycle.
REQ-017 On every push, PC SHALL advance by 1; PC == IMEM_WORDS-1 SHALL wrap to 0.
REQ-018 Full without a transfer: no push occurs, and PC, imem_addr and the buffer contents SHALL hold.
REQ-019 Pop: on a transfer the head SHALL advance by one entry.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged.
REQ-021 Empty: inst_valid = 0, and inst_data and inst_pc hold their last values; an instruction pushed in cycle N SHALL appear at the head in cycle N+1 (latency 1).
REQ-022 inst_valid = (count != 0); inst_data and inst_pc SHALL be driven from registered buffer storage.
REQ-023 Redirect, which has priority over push: the next cycle count = 0 and PC = redirect_pc mod IMEM_WORDS, and no push occurs in the redirect cycle.
REQ-024 Redirect in the same cycle as a transfer: the transfer completes, then the flush applies.
REQ-025 Back-to-back redirects: the last one SHALL win.
REQ-026 Buffer pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.
REQ-027 With inst_ready held at 1 and no redirect, throughput SHALL be one instruction per cycle after the first.

Reset
REQ-028 On a clk edge with reset = 1: PC = RESET_PC, count = 0, pointers = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-029 Reset SHALL override redirect, push and pop.
REQ-030 Reset asserted mid-operation SHALL discard all buffered instructions.
REQ-031 Fetch SHALL resume at RESET_PC on the first cycle after reset deasserts.

Configuration
REQ-032 Macro K_FETCH_STALL_CNT_EN, when defined, SHALL add output stall_cnt [31:0].
REQ-033 stall_cnt SHALL increment on each cycle with count == FIFO_DEPTH and no transfer, saturating at 0xFFFFFFFF.
REQ-034 stall_cnt SHALL be cleared by reset and SHALL not be cleared by redirect.
REQ-035 With K_FETCH_STALL_CNT_EN undefined, the stall_cnt port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-036 Sequential fetch: memory[i] = 0x100+i, reset released, inst_ready = 1 -> inst_data 0x100, 0x101, 0x102... on consecutive cycles with inst_pc 0, 1, 2, first valid one cycle after reset release.
REQ-037 Backpressure: inst_ready = 0 for 10 cycles (FIFO_DEPTH = 4) -> exactly 4 entries (pc 0..3) held, imem_addr frozen at 4, stall_cnt = 6 with the macro defined; ready = 1 -> pc 0..7 in order with none lost.
REQ-038 Redirect: redirect = 1, redirect_pc = 0x20 while 3 entries are buffered -> next cycle inst_valid = 0, then inst_pc 0x20 with inst_data = memory[0x20].
REQ-039 Wrap: redirect_pc = 1022, IMEM_WORDS = 1024 -> inst_pc sequence 1022, 1023, 0, 1; redirect_pc = 0x401 -> fetch starts at 1.
REQ-040 Simultaneous full and pop: buffer full, inst_ready = 1 for one cycle -> count stays 4, one new entry is written and imem_addr advances by 1.
REQ-041 Mid-operation reset: reset for 1 cycle with a full buffer -> inst_valid = 0 and imem_addr = RESET_PC the next cycle, stall_cnt = 0.
